// File: rtl/spi_wr_arbiter.sv
// Round-robin arbiter sharing one write port between a buffered SPI write
// stream and a req/gnt host requester.
module spi_wr_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spi_wr_en,
    input  logic [ADDR_W-1:0]             spi_wr_address,
    input  logic [DATA_W-1:0]             spi_wr_data,
    input  logic                          host_req,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [DATA_W-1:0]             host_data,
    output logic                          host_gnt,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ready,
    input  logic                          clr_overflow,
    output logic                          spi_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SPI_XFER,
        HOST_XFER
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic              spi_pend;
    logic              host_pend;
    logic              last_host;
    logic              last_host_n;
    logic              we_n;
    logic              gnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;

    assign full      = fifo_level == LW'(FIFO_DEPTH);
    assign push      = spi_wr_en && (!full || pop);
    assign drop      = spi_wr_en && full && !pop;
    assign spi_pend  = fifo_level != '0;
    assign host_pend = host_req && !host_gnt;

    // Storage needs no reset: only entries below fifo_level are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= spi_wr_address;
            fifo_data[wr_ptr] <= spi_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            spi_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (pop && !push) fifo_level <= fifo_level - 1'b1;
            if (drop)              spi_overflow <= 1'b1;
            else if (clr_overflow) spi_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            host_gnt  <= 1'b0;
            last_host <= 1'b1;
        end else begin
            state     <= state_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= data_n;
            host_gnt  <= gnt_n;
            last_host <= last_host_n;
        end
    end

    always_comb begin
        state_n     = state;
        we_n        = mem_we;
        addr_n      = mem_addr;
        data_n      = mem_wdata;
        gnt_n       = 1'b0;
        last_host_n = last_host;
        pop         = 1'b0;
        unique case (state)
            IDLE: begin
                // On a tie the source not served last time wins.
                if (spi_pend && (!host_pend || last_host)) begin
                    state_n = SPI_XFER;
                    we_n    = 1'b1;
                    addr_n  = fifo_addr[rd_ptr];
                    data_n  = fifo_data[rd_ptr];
                end else if (host_pend) begin
                    state_n = HOST_XFER;
                    we_n    = 1'b1;
                    addr_n  = host_addr;
                    data_n  = host_data;
                end
            end
            SPI_XFER: begin
                if (mem_ready) begin
                    state_n     = IDLE;
                    we_n        = 1'b0;
                    last_host_n = 1'b0;
                    pop         = 1'b1;
                end
            end
            HOST_XFER: begin
                if (mem_ready) begin
                    state_n     = IDLE;
                    we_n        = 1'b0;
                    last_host_n = 1'b1;
                    gnt_n       = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_wr_arbiter.sv
// Self-checking bench for spi_wr_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_spi_wr_arbiter;

    localparam int AW    = 24;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_wr_en = 1'b0;
    logic [AW-1:0] spi_wr_address = '0;
    logic [DW-1:0] spi_wr_data = '0;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_data = '0;
    logic          host_gnt;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          spi_overflow;
    logic [2:0]    fifo_level;

    always #5 clk = ~clk;

    spi_wr_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi_wr_en      (spi_wr_en),
        .spi_wr_address (spi_wr_address),
        .spi_wr_data    (spi_wr_data),
        .host_req       (host_req),
        .host_addr      (host_addr),
        .host_data      (host_data),
        .host_gnt       (host_gnt),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .clr_overflow   (clr_overflow),
        .spi_overflow   (spi_overflow),
        .fifo_level     (fifo_level)
    );

    typedef struct {
        bit          rst;
        bit          en;
        logic [23:0] sa;
        logic [31:0] sd;
        bit          hreq;
        bit          rdy;
        bit          e_we;
        logic [23:0] e_a;
        logic [31:0] e_d;
        bit          e_gnt;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t        tbl [17];
    int          checks = 0;
    int          errors = 0;
    logic [55:0] log_q [$];
    logic [55:0] sq [$];
    logic [55:0] exp_w [5];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        logic          acc;
        logic [55:0]   w;
        acc = mem_we && mem_ready;
        w   = {mem_addr, mem_wdata};
        @(posedge clk);
        #1;
        if (acc) log_q.push_back(w);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        spi_wr_en      = 1'b0;
        spi_wr_address = '0;
        spi_wr_data    = '0;
        host_req       = 1'b0;
        host_addr      = '0;
        host_data      = '0;
        mem_ready      = 1'b0;
        clr_overflow   = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"},   64'(mem_we), 64'(0));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_data"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_gnt"},  64'(host_gnt), 64'(0));
        chk({tag, "_ovf"},  64'(spi_overflow), 64'(0));
        chk({tag, "_lvl"},  64'(fifo_level), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // rst en  sa            sd            hreq rdy  we  a             d             gnt lvl
        tbl[0]  = '{1'b1, 1'b1, 24'h123456, 32'hF1F1F1F1, 1'b0, 1'b1, 1'b0, 24'h000000, 32'h00000000, 1'b0, 3'd1};
        tbl[1]  = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 24'h123456, 32'hF1F1F1F1, 1'b0, 3'd1};
        tbl[2]  = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 24'h123456, 32'hF1F1F1F1, 1'b0, 3'd0};
        tbl[3]  = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 24'h123456, 32'hF1F1F1F1, 1'b0, 3'd0};
        tbl[4]  = '{1'b1, 1'b1, 24'h000111, 32'h11111111, 1'b0, 1'b1, 1'b0, 24'h000000, 32'h00000000, 1'b0, 3'd1};
        tbl[5]  = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 24'h000111, 32'h11111111, 1'b0, 3'd1};
        tbl[6]  = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 24'h000111, 32'h11111111, 1'b0, 3'd0};
        tbl[7]  = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 24'hABCDEF, 32'h12345678, 1'b0, 3'd0};
        tbl[8]  = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 24'hABCDEF, 32'h12345678, 1'b1, 3'd0};
        tbl[9]  = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 32'h12345678, 1'b0, 3'd0};
        tbl[10] = '{1'b0, 1'b1, 24'h000222, 32'h22222222, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 32'h12345678, 1'b0, 3'd1};
        tbl[11] = '{1'b0, 1'b1, 24'h000333, 32'h33333333, 1'b0, 1'b1, 1'b1, 24'h000222, 32'h22222222, 1'b0, 3'd2};
        tbl[12] = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 24'h000222, 32'h22222222, 1'b0, 3'd1};
        tbl[13] = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b1, 1'b1, 1'b1, 24'hABCDEF, 32'h12345678, 1'b0, 3'd1};
        tbl[14] = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 24'hABCDEF, 32'h12345678, 1'b1, 3'd1};
        tbl[15] = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 24'h000333, 32'h33333333, 1'b0, 3'd1};
        tbl[16] = '{1'b0, 1'b0, 24'h000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 24'h000333, 32'h33333333, 1'b0, 3'd0};

        // Reset values, then an asynchronous reset in the middle of a write.
        do_reset();
        #1;
        chk_zero("reset");
        step();
        mem_ready      = 1'b0;
        spi_wr_en      = 1'b1;
        spi_wr_address = 24'h0ABCDE;
        spi_wr_data    = 32'hCAFEF00D;
        step();
        spi_wr_en = 1'b0;
        step();
        chk("pre_rst_we", 64'(mem_we), 64'(1));
        chk("pre_rst_addr", 64'(mem_addr), 64'(24'h0ABCDE));
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        #1;
        rst_n = 1'b1;

        // Single SPI write latency and round-robin tie breaking.
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst) begin
                step();
                do_reset();
            end
            spi_wr_en      = tbl[i].en;
            spi_wr_address = tbl[i].sa;
            spi_wr_data    = tbl[i].sd;
            host_req       = tbl[i].hreq;
            host_addr      = 24'hABCDEF;
            host_data      = 32'h12345678;
            mem_ready      = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d_we", i),   64'(mem_we), 64'(tbl[i].e_we));
            chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(tbl[i].e_a));
            chk($sformatf("vec%0d_data", i), 64'(mem_wdata), 64'(tbl[i].e_d));
            chk($sformatf("vec%0d_gnt", i),  64'(host_gnt), 64'(tbl[i].e_gnt));
            chk($sformatf("vec%0d_lvl", i),  64'(fifo_level), 64'(tbl[i].e_lvl));
        end

        // Host write held under 10 cycles of backpressure.
        do_reset();
        host_req  = 1'b1;
        host_addr = 24'hABCDEF;
        host_data = 32'h12345678;
        step();
        chk("bp_we", 64'(mem_we), 64'(1));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_we",   64'(mem_we), 64'(1));
            chk("bp_hold_addr", 64'(mem_addr), 64'(24'hABCDEF));
            chk("bp_hold_data", 64'(mem_wdata), 64'(32'h12345678));
            chk("bp_hold_gnt",  64'(host_gnt), 64'(0));
        end
        mem_ready = 1'b1;
        step();
        chk("bp_done_we", 64'(mem_we), 64'(0));
        chk("bp_done_gnt", 64'(host_gnt), 64'(1));
        host_req = 1'b0;
        step();
        chk("bp_gnt_pulse", 64'(host_gnt), 64'(0));

        // Overflow, clear, and a push on the same edge as a pop of a full FIFO.
        do_reset();
        log_q.delete();
        for (int i = 0; i < 5; i++) begin
            spi_wr_en      = 1'b1;
            spi_wr_address = 24'h000010 + 24'(i);
            spi_wr_data    = 32'hD0 + 32'(i);
            step();
        end
        spi_wr_en = 1'b0;
        chk("ovf_lvl", 64'(fifo_level), 64'(4));
        chk("ovf_set", 64'(spi_overflow), 64'(1));
        chk("ovf_head", 64'(mem_addr), 64'(24'h000010));
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("ovf_clr", 64'(spi_overflow), 64'(0));
        spi_wr_en      = 1'b1;
        spi_wr_address = 24'h0000FF;
        spi_wr_data    = 32'h000000FF;
        mem_ready      = 1'b1;
        step();
        spi_wr_en = 1'b0;
        chk("fullpp_lvl", 64'(fifo_level), 64'(4));
        chk("fullpp_ovf", 64'(spi_overflow), 64'(0));
        for (int i = 0; i < 40 && log_q.size() < 5; i++) step();
        chk("drain_count", 64'(log_q.size()), 64'(5));
        exp_w[0] = {24'h000010, 32'hD0};
        exp_w[1] = {24'h000011, 32'hD1};
        exp_w[2] = {24'h000012, 32'hD2};
        exp_w[3] = {24'h000013, 32'hD3};
        exp_w[4] = {24'h0000FF, 32'hFF};
        for (int i = 0; i < 5; i++) begin
            if (i < log_q.size())
                chk($sformatf("drain_w%0d", i), 64'(log_q[i]), 64'(exp_w[i]));
        end
        chk("drain_lvl", 64'(fifo_level), 64'(0));
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            spi_wr_en      = 1'b1;
            spi_wr_address = 24'h000020 + 24'(i);
            step();
        end
        chk("ovf2_set", 64'(spi_overflow), 64'(1));
        clr_overflow = 1'b1;
        step();
        chk("ovf_set_wins", 64'(spi_overflow), 64'(1));
        spi_wr_en = 1'b0;
        step();
        clr_overflow = 1'b0;
        chk("ovf2_clr", 64'(spi_overflow), 64'(0));

        // Randomized traffic against a queue-level reference model.
        begin
            bit          ovf_m;
            bit          gnt_exp;
            bit          hold_exp;
            bit          idle_exp;
            bit          acc;
            bit          pop;
            bit          drop;
            logic [23:0] hold_a;
            logic [31:0] hold_d;
            int          hwait;
            step();
            do_reset();
            step();
            sq.delete();
            ovf_m    = 1'b0;
            gnt_exp  = 1'b0;
            hold_exp = 1'b0;
            idle_exp = 1'b0;
            hold_a   = '0;
            hold_d   = '0;
            hwait    = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                bit drain;
                drain = cyc >= 2700;
                chk("rnd_lvl", 64'(fifo_level), 64'(sq.size()));
                chk("rnd_ovf", 64'(spi_overflow), 64'(ovf_m));
                chk("rnd_gnt", 64'(host_gnt), 64'(gnt_exp));
                if (hold_exp) begin
                    chk("rnd_hold_we", 64'(mem_we), 64'(1));
                    chk("rnd_hold_addr", 64'(mem_addr), 64'(hold_a));
                    chk("rnd_hold_data", 64'(mem_wdata), 64'(hold_d));
                end
                if (idle_exp) chk("rnd_idle_gap", 64'(mem_we), 64'(0));
                if (host_req && !host_gnt) hwait++;
                else hwait = 0;
                if (hwait == 40) chk("rnd_host_starved", 64'(hwait), 64'(0));

                if (!host_req || host_gnt) begin
                    if (!drain && $urandom_range(2) == 0) begin
                        host_req  = 1'b1;
                        host_addr = {1'b1, 23'($urandom)};
                        host_data = $urandom;
                    end else begin
                        host_req = 1'b0;
                    end
                end
                spi_wr_en      = !drain && ($urandom_range(99) < 35);
                spi_wr_address = {1'b0, 23'($urandom)};
                spi_wr_data    = $urandom;
                mem_ready      = drain || ($urandom_range(99) < 65);
                clr_overflow   = !drain && ($urandom_range(99) < 4);

                acc     = mem_we && mem_ready;
                pop     = 1'b0;
                gnt_exp = 1'b0;
                if (acc) begin
                    if (!mem_addr[23]) begin
                        chk("rnd_spi_nonempty", 64'(sq.size() != 0), 64'(1));
                        if (sq.size() != 0) begin
                            chk("rnd_spi_write", 64'({mem_addr, mem_wdata}),
                                64'(sq[0]));
                            pop = 1'b1;
                        end
                    end else begin
                        chk("rnd_host_req", 64'(host_req), 64'(1));
                        chk("rnd_host_write", 64'({mem_addr, mem_wdata}),
                            64'({host_addr, host_data}));
                        gnt_exp = 1'b1;
                    end
                end
                hold_exp = mem_we && !mem_ready;
                hold_a   = mem_addr;
                hold_d   = mem_wdata;
                idle_exp = acc;
                drop = spi_wr_en && (sq.size() == DEPTH) && !pop;
                if (pop) void'(sq.pop_front());
                if (spi_wr_en && !drop)
                    sq.push_back({spi_wr_address, spi_wr_data});
                if (drop) ovf_m = 1'b1;
                else if (clr_overflow) ovf_m = 1'b0;
                @(posedge clk);
                #1;
            end
            chk("rnd_end_lvl", 64'(fifo_level), 64'(0));
            chk("rnd_end_host", 64'(host_req && !host_gnt), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
